// File: rtl/popcnt_seq.sv
// popcnt_seq: iterative population counter.
//
// Counts the ones in a WIDTH-bit mask, CHUNK bits per clock. The same block
// produces clz (fed the leading-zero mask), ctz (fed the reversed mask) and
// cpop (fed the operand itself). Latency is fixed at NCHUNK edges from
// accept to OutValid, whatever the data.
//
// Handshake: a transfer happens on a rising clk edge where valid and ready
// are both 1. The input side transfers when InValid & InReady, and the
// output side transfers when OutValid & OutReady. While OutValid is 1 and
// OutReady is 0, Count holds its value. InValid is ignored while InReady is 0.
//
// Ports
//   clk        clock
//   reset      synchronous, active-high reset
//   Flush      abort the operation in progress and discard its result
//   InValid    A is valid (start request)
//   InReady    block can accept an operand (IDLE)
//   A          mask to count, sampled only at the accepting edge
//   OutValid   Count is valid (DONE)
//   OutReady   consumer takes Count
//   Count      number of ones in the accepted A (registered)
//   dbg_state  current FSM state, for checkers and waveform debug
module popcnt_seq #(
    parameter int WIDTH = 64,
    parameter int CHUNK = 8,
    localparam int NCHUNK = WIDTH / CHUNK,
    localparam int CW = $clog2(WIDTH + 1),
    localparam int IW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Flush,
    input  logic             InValid,
    output logic             InReady,
    input  logic [WIDTH-1:0] A,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [CW-1:0]    Count,
    output logic [1:0]       dbg_state
);

    generate
        if (WIDTH % CHUNK != 0) begin : g_bad_chunk
            $error("popcnt_seq: WIDTH must be a multiple of CHUNK");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    acc;
    logic [IW-1:0]    idx;
    logic [CW-1:0]    chunk_ones;
    logic             accept;
    logic             last_chunk;

    // Ones in the chunk currently at the bottom of the shift register.
    always_comb begin
        chunk_ones = '0;
        for (int i = 0; i < CHUNK; i++) begin
            chunk_ones = chunk_ones + CW'(shreg[i]);
        end
    end

    assign accept     = (state == IDLE) && InValid;
    assign last_chunk = (idx == IW'(NCHUNK - 1));

    // Next-state logic. Flush overrides every handshake, including an
    // accept in IDLE.
    always_comb begin
        state_next = state;
        if (Flush) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (InValid) state_next = COUNT;
                COUNT:   if (last_chunk) state_next = DONE;
                DONE:    if (OutReady) state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            shreg <= '0;
            acc   <= '0;
            idx   <= '0;
        end else begin
            state <= state_next;
            if (Flush) begin
                shreg <= '0;
                acc   <= '0;
                idx   <= '0;
            end else if (accept) begin
                shreg <= A;
                acc   <= '0;
                idx   <= '0;
            end else if (state == COUNT) begin
                // The accumulator is CW bits wide and never exceeds WIDTH.
                acc   <= acc + chunk_ones;
                shreg <= shreg >> CHUNK;
                idx   <= idx + IW'(1);
            end
        end
    end

    assign InReady   = (state == IDLE);
    assign OutValid  = (state == DONE);
    assign Count     = acc;
    assign dbg_state = state;

endmodule

// File: tb/tb_popcnt_seq.sv
// Self-checking bench for popcnt_seq at WIDTH=32, CHUNK=8.
// Inputs are driven and outputs sampled on the falling edge. Expected counts
// come from $countones of each accepted mask and are queued in order.
module tb_popcnt_seq;

    localparam int WIDTH  = 32;
    localparam int CHUNK  = 8;
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = $clog2(WIDTH + 1);

    logic             clk = 1'b0;
    logic             reset;
    logic             Flush;
    logic             InValid;
    logic             InReady;
    logic [WIDTH-1:0] A;
    logic             OutValid;
    logic             OutReady;
    logic [CW-1:0]    Count;
    logic [1:0]       dbg_state;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] exp_q[$];

    popcnt_seq #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk(clk), .reset(reset), .Flush(Flush),
        .InValid(InValid), .InReady(InReady), .A(A),
        .OutValid(OutValid), .OutReady(OutReady), .Count(Count),
        .dbg_state(dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_idle(input string tag, input logic [31:0] exp_count);
        check({tag, "_inready"}, 32'(InReady), 32'd1);
        check({tag, "_outvalid"}, 32'(OutValid), 32'd0);
        check({tag, "_count"}, 32'(Count), exp_count);
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b1;
        for (int i = 0; i < cycles; i++) step();
        reset = 1'b0;
        check_idle("reset", 32'd0);
    endtask

    // Accept mask a, check latency and result, stall the output for 'stall'
    // cycles while offering junk operands, then complete the handshake.
    // Called and returns on a falling edge; returns with the block in IDLE.
    task automatic run_op(input logic [WIDTH-1:0] a, input int stall);
        int lat;
        logic [31:0] exp_cnt;
        logic [CW-1:0] held;
        check("pre_inready", 32'(InReady), 32'd1);
        InValid  = 1'b1;
        A        = a;
        OutReady = 1'b0;
        @(posedge clk);
        exp_q.push_back(32'($countones(a)));
        @(negedge clk);
        InValid = 1'b0;
        A       = WIDTH'($urandom);
        check("count_clr", 32'(Count), 32'd0);
        check("busy_inready", 32'(InReady), 32'd0);
        lat = 0;
        while (!OutValid && lat < 20) begin
            step();
            lat++;
        end
        check("latency", 32'(lat), 32'(NCHUNK));
        if (exp_q.size() != 0) exp_cnt = exp_q.pop_front();
        else exp_cnt = 32'hFFFF_FFFF;
        check("count", 32'(Count), exp_cnt);
        held = Count;
        for (int i = 0; i < stall; i++) begin
            InValid = 1'b1;
            A       = WIDTH'($urandom);
            step();
            check("stall_count", 32'(Count), 32'(held));
            check("stall_outvalid", 32'(OutValid), 32'd1);
            check("stall_inready", 32'(InReady), 32'd0);
        end
        InValid  = 1'b0;
        OutReady = 1'b1;
        step();
        OutReady = 1'b0;
        check_idle("post", 32'(held));
    endtask

    // Accept a, let it count for 'edges' edges, then abort with Flush or reset.
    task automatic abort_op(input logic [WIDTH-1:0] a, input int edges, input bit use_reset);
        InValid = 1'b1;
        A       = a;
        step();
        InValid = 1'b0;
        for (int i = 0; i < edges; i++) step();
        if (use_reset) reset = 1'b1;
        else Flush = 1'b1;
        step();
        reset = 1'b0;
        Flush = 1'b0;
        check_idle(use_reset ? "rst_abort" : "flush_abort", 32'd0);
        for (int i = 0; i < NCHUNK + 2; i++) begin
            step();
            check("abort_no_outvalid", 32'(OutValid), 32'd0);
        end
    endtask

    initial begin
        reset    = 1'b1;
        Flush    = 1'b0;
        InValid  = 1'b0;
        A        = '0;
        OutReady = 1'b0;
        @(negedge clk);
        do_reset(2);

        run_op(32'hFFF0_0000, 0);
        run_op(32'hFFFF_FFFF, 0);
        run_op(32'h0000_0000, 0);
        run_op(32'h8000_0001, 0);
        run_op(32'h0000_007F, 5);

        // Flush mid-COUNT, then a fresh op.
        abort_op(32'hFFFF_00FF, 2, 1'b0);
        run_op(32'h0000_0001, 0);
        // Flush while DONE (NCHUNK edges after accept) discards the result.
        abort_op(32'h0F0F_0F0F, NCHUNK, 1'b0);
        // Reset mid-COUNT.
        abort_op(32'h1234_5678, 2, 1'b1);
        run_op(32'h0000_0001, 0);

        // Flush coinciding with InValid in IDLE: nothing accepted, Count cleared.
        run_op(32'h0000_00FF, 0);
        Flush   = 1'b1;
        InValid = 1'b1;
        A       = 32'hFFFF_FFFF;
        step();
        Flush   = 1'b0;
        InValid = 1'b0;
        check_idle("flush_vs_accept", 32'd0);
        for (int i = 0; i < NCHUNK + 2; i++) begin
            step();
            check("flush_vs_accept_idle", 32'(InReady), 32'd1);
        end

        // Random masks, back-to-back, random output stalls.
        for (int n = 0; n < 40; n++) begin
            logic [WIDTH-1:0] m;
            case ($urandom_range(0, 3))
                0: m = WIDTH'($urandom) & WIDTH'($urandom);
                1: m = WIDTH'($urandom) | WIDTH'($urandom);
                default: m = WIDTH'($urandom);
            endcase
            run_op(m, $urandom_range(0, 3));
        end

        check("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
